// File: rtl/uart_rx_axis_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : uart_rx_axis_packer                                        |
// | Brief    : Packs UART RX bytes into AXI-Stream packets closed by an   |
// |            idle timeout or a maximum length. Optional: OVF_CNT_EN     |
// |            adds an 8-bit saturating dropped-byte counter (ovf_cnt).   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module uart_rx_axis_packer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 9548,
  parameter int MAX_PKT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
`ifdef OVF_CNT_EN
  output logic             ovf,
  output logic [7:0]       ovf_cnt
`else
  output logic             ovf
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_TW = $clog2(TIMEOUT_CYC);
  localparam int c_BW = $clog2(MAX_PKT);
  localparam logic [c_TW-1:0] c_TMO_MAX = c_TW'(TIMEOUT_CYC - 1);
  localparam logic [c_BW-1:0] c_PKT_MAX = c_BW'(MAX_PKT - 1);
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);

  typedef enum logic [0:0] {P_EMPTY = 1'b0, P_HOLD = 1'b1} pend_state_t;

  pend_state_t      r_state;
  logic [WIDTH-1:0] r_pend;
  logic [c_TW-1:0]  r_tmo_cnt;
  logic [c_BW-1:0]  r_byte_cnt;
  logic             r_ovf;

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_valid;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_push_last;
  logic             w_drop;
  logic [c_TW-1:0]  w_tmo_next;
  logic             w_tmo_hit;

  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && (!r_out_valid || m_axis_tready);
  assign w_tmo_next = (r_tmo_cnt == c_TMO_MAX) ? c_TMO_MAX : r_tmo_cnt + c_TW'(1);
  // Expiry is the clock on which the counter reaches (or sits at) its ceiling.
  assign w_tmo_hit  = (w_tmo_next == c_TMO_MAX);

  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_drop      = 1'b0;
    if (r_state == P_HOLD) begin
      if (rx_valid) begin
        if (w_full) begin
          w_drop = 1'b1;
        end else begin
          w_push      = 1'b1;
          w_push_last = (r_byte_cnt == c_PKT_MAX);
        end
      end else if (w_tmo_hit && !w_full) begin
        w_push      = 1'b1;
        w_push_last = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= P_EMPTY;
      r_pend     <= '0;
      r_tmo_cnt  <= '0;
      r_byte_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_ovf <= w_drop;
      if (w_push) begin
        r_byte_cnt <= w_push_last ? '0 : r_byte_cnt + c_BW'(1);
      end
      case (r_state)
        P_EMPTY: begin
          if (rx_valid) begin
            r_pend    <= rx_data;
            r_tmo_cnt <= '0;
            r_state   <= P_HOLD;
          end
        end
        P_HOLD: begin
          if (rx_valid && !w_full) begin
            r_pend    <= rx_data;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= w_tmo_next;
            if (!rx_valid && w_push) begin
              r_state <= P_EMPTY;
            end
          end
        end
        default: r_state <= P_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_push_last, r_pend};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage holds its byte until accepted; refills from the FIFO on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      {r_out_last, r_out_data} <= r_mem[r_rd_ptr];
    end else if (m_axis_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_out_data;
  assign m_axis_tlast  = r_out_last;
  assign m_axis_tvalid = r_out_valid;
  assign ovf           = r_ovf;

`ifdef OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_axis_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_uart_rx_axis_packer                                     |
// | Brief    : Directed self-checking bench for uart_rx_axis_packer.      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_uart_rx_axis_packer;

  localparam int c_T = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tready;
  logic       ovf;
`ifdef OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovf_pulses = 0;
  int stab_err = 0;
  logic [31:0] outq[$];
  int stampq[$];
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  uart_rx_axis_packer #(
    .WIDTH(8), .DEPTH(16), .TIMEOUT_CYC(c_T), .MAX_PKT(64)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
`ifdef OVF_CNT_EN
    .ovf(ovf), .ovf_cnt(ovf_cnt)
`else
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observes the stream one time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        outq.push_back({23'd0, m_axis_tlast, m_axis_tdata});
        stampq.push_back(cyc);
      end
      if (ovf) ovf_pulses++;
      if (hold_prev && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        stab_err++;
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_entry(input string tag, input int idx, input logic last, input logic [7:0] d);
    logic [31:0] obs;
    obs = (idx < outq.size()) ? outq[idx] : 32'hDEAD_BEEF;
    check($sformatf("%s[%0d]", tag, idx), obs, {23'd0, last, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output int stamp);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 stamp = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    int t0, t1, ovf_before;
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0; m_axis_tready = 1'b0;
    idle(3);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
    check("rst_tdata",  {24'd0, m_axis_tdata},  32'd0);
    check("rst_ovf",    {31'd0, ovf},           32'd0);
`ifdef OVF_CNT_EN
    check("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif
    @(negedge clk) rst = 1'b1;
    m_axis_tready = 1'b1;

    // Three spaced bytes, packet closed by idle timeout.
    outq.delete(); stampq.delete();
    send_byte(8'h41, t0); idle(18);
    send_byte(8'h42, t0); idle(18);
    send_byte(8'h43, t0); idle(c_T + 10);
    check("abc_count", outq.size(), 32'd3);
    check_entry("abc", 0, 1'b0, 8'h41);
    check_entry("abc", 1, 1'b0, 8'h42);
    check_entry("abc", 2, 1'b1, 8'h43);
    check("abc_tlast_delay", (stampq.size() > 2) ? stampq[2] - t0 : -1, c_T);

    // New byte on the exact expiry clock keeps the packet open.
    outq.delete(); stampq.delete();
    send_byte(8'h11, t0); idle(c_T - 3);
    send_byte(8'h22, t1); idle(c_T + 10);
    check("race_count", outq.size(), 32'd2);
    check_entry("race", 0, 1'b0, 8'h11);
    check_entry("race", 1, 1'b1, 8'h22);
    check("race_tlast_delay", (stampq.size() > 1) ? stampq[1] - t1 : -1, c_T);

    // Seventy bytes: max-length packet then a short timeout packet.
    outq.delete(); stampq.delete();
    for (int i = 0; i < 70; i++) begin
      send_byte(8'(i + 1), t0);
      idle(18);
    end
    idle(c_T + 10);
    check("long_count", outq.size(), 32'd70);
    for (int i = 0; i < 70; i++)
      check_entry("long", i, (i == 63) || (i == 69), 8'(i + 1));

    // Backpressure: output stage, FIFO and pending fill, the next byte drops.
    outq.delete(); stampq.delete();
    m_axis_tready = 1'b0;
    ovf_before = ovf_pulses;
    for (int i = 0; i < 18; i++) begin
      send_byte(8'hA0 + 8'(i), t0);
      idle(1);
    end
    check("bp_ovf_idle", {31'd0, ovf}, 32'd0);
    send_byte(8'hFE, t0);
    check("bp_ovf_pulse", {31'd0, ovf}, 32'd1);
    idle(1);
    check("bp_ovf_fall", {31'd0, ovf}, 32'd0);
    idle(c_T + 5);
    check("bp_ovf_count", ovf_pulses - ovf_before, 32'd1);
`ifdef OVF_CNT_EN
    check("bp_ovf_cnt", {24'd0, ovf_cnt}, 32'd1);
`endif
    check("bp_none_out", outq.size(), 32'd0);
    m_axis_tready = 1'b1;
    idle(40);
    check("bp_count", outq.size(), 32'd18);
    for (int i = 0; i < 18; i++)
      check_entry("bp", i, i == 17, 8'hA0 + 8'(i));

    // Alternating ready with eight queued bytes.
    outq.delete(); stampq.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hC0 + 8'(i), t0);
      idle(1);
    end
    idle(c_T + 5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      m_axis_tready = ~m_axis_tready;
    end
    m_axis_tready = 1'b1;
    idle(5);
    check("tog_count", outq.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      check_entry("tog", i, i == 7, 8'hC0 + 8'(i));
    check("stable_hold", stab_err, 32'd0);

    // Reset mid-packet discards everything.
    outq.delete(); stampq.delete();
    m_axis_tready = 1'b0;
    send_byte(8'h55, t0); idle(2);
    send_byte(8'h66, t0); idle(2);
    check("pre_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    check("pre_rst_tdata",  {24'd0, m_axis_tdata},  32'h55);
    @(negedge clk) rst = 1'b0;
    #1;
    check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("mid_rst_tdata",  {24'd0, m_axis_tdata},  32'd0);
    check("mid_rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    m_axis_tready = 1'b1;
    rx_data = 8'h77;
    rx_valid = 1'b1;
    @(negedge clk) rx_valid = 1'b0;
    idle(c_T + 10);
    check("post_rst_count", outq.size(), 32'd1);
    check_entry("post_rst", 0, 1'b1, 8'h77);
    check("ovf_total", ovf_pulses, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
